// File: rtl/soc1_sysid_checker.sv
// System ID checker: reads the ID and build timestamp words from a sysid
// slave over Avalon-MM and compares them against build-time constants.
//
//   state | meaning
//   IDLE  | waiting for start, status held from previous sequence
//   RD_ID | read strobe on word 0 (system ID)
//   RD_TS | read strobe on word 1 (build timestamp)
//   GAP   | one idle bus cycle between a timed-out attempt and its retry
//   CHECK | register the compare results
//   DONE  | one-cycle done pulse
module soc1_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        GAP   = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    // The attempt times out on the stall cycle that would bring the count to
    // TIMEOUT_CYCLES, so an attempt lasts exactly TIMEOUT_CYCLES stall cycles.
    localparam logic [15:0] TC_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    state_t      state;
    state_t      state_next;
    logic [15:0] tcnt;
    logic [3:0]  rcnt;
    logic        gap_word;

    logic accept;
    logic capture_id;
    logic capture_ts;
    logic retry;
    logic give_up;
    logic timed_out;

    // Next-state decode and bus/status strobes; capture takes priority over timeout.
    always_comb begin
        state_next  = state;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        accept      = 1'b0;
        capture_id  = 1'b0;
        capture_ts  = 1'b0;
        retry       = 1'b0;
        give_up     = 1'b0;
        timed_out   = avm_waitrequest && (tcnt == TC_LAST);
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RD_ID;
                end
            end
            RD_ID, RD_TS: begin
                avm_read    = 1'b1;
                avm_address = (state == RD_TS);
                if (!avm_waitrequest) begin
                    capture_id = (state == RD_ID);
                    capture_ts = (state == RD_TS);
                    state_next = (state == RD_ID) ? RD_TS : CHECK;
                end else if (timed_out) begin
                    if (rcnt < RETRY_MAX) begin
                        retry      = 1'b1;
                        state_next = GAP;
                    end else begin
                        give_up    = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            GAP:     state_next = gap_word ? RD_TS : RD_ID;
            CHECK:   state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Stall counter (per attempt) and retry counter (per word); gap_word
    // remembers which read to resume after GAP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tcnt     <= '0;
            rcnt     <= '0;
            gap_word <= 1'b0;
        end else begin
            if (state_next != state)
                tcnt <= '0;
            else if (avm_read && avm_waitrequest)
                tcnt <= tcnt + 16'd1;

            if (accept || capture_id)
                rcnt <= '0;
            else if (retry)
                rcnt <= rcnt + 4'd1;

            if (retry)
                gap_word <= (state == RD_TS);
        end
    end

    // Captured words and result flags, held until the next accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value    <= '0;
            ts_value    <= '0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (capture_id) id_value <= avm_readdata;
            if (capture_ts) ts_value <= avm_readdata;
            if (give_up)    timeout_err <= 1'b1;
            if (state == CHECK) begin
                id_ok <= (id_value == EXPECTED_ID);
                ts_ok <= (ts_value == EXPECTED_TS);
            end
        end
    end

endmodule

// File: tb/tb_soc1_sysid_checker.sv
// Directed bench for soc1_sysid_checker with a short timeout and one retry.
module tb_soc1_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h6722_B9AE;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        waitreq;
    logic [31:0] id_word;
    logic [31:0] ts_word;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int checks = 0;
    int errors = 0;

    assign avm_readdata = avm_address ? ts_word : id_word;

    soc1_sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (4),
        .MAX_RETRIES    (1)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (waitreq),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout_err     (timeout_err),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start in IDLE, then drive waitrequest from wait_pat (bit k = cycle k
    // after the start edge) and record avm_read/avm_address until done.
    task automatic run_seq(input logic [31:0] wait_pat, output int cyc,
                           output logic [31:0] rd_pat, output logic [31:0] ad_pat);
        rd_pat = '0;
        ad_pat = '0;
        cyc    = 0;
        @(negedge clock);
        start   = 1'b1;
        waitreq = wait_pat[0];
        for (int k = 1; k < 32; k++) begin
            @(negedge clock);
            start     = 1'b0;
            waitreq   = wait_pat[k];
            rd_pat[k] = avm_read;
            ad_pat[k] = avm_address;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    int          cyc;
    logic [31:0] rd_pat;
    logic [31:0] ad_pat;
    logic [31:0] done_pat;
    logic        seen;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        waitreq = 1'b0;
        id_word = 32'h0000_0000;
        ts_word = EXP_TS;

        repeat (2) @(negedge clock);
        check("rst_read",    {31'd0, avm_read},    32'd0);
        check("rst_addr",    {31'd0, avm_address}, 32'd0);
        check("rst_busy",    {31'd0, busy},        32'd0);
        check("rst_done",    {31'd0, done},        32'd0);
        check("rst_status",  {29'd0, id_ok, ts_ok, timeout_err}, 32'd0);
        check("rst_id_val",  id_value, 32'd0);
        check("rst_ts_val",  ts_value, 32'd0);
        reset_n = 1'b1;

        // Zero-wait, both words match.
        run_seq(32'h0, cyc, rd_pat, ad_pat);
        check("zw_latency", cyc, 32'd4);
        check("zw_read",    rd_pat, 32'h6);
        check("zw_addr",    ad_pat, 32'h4);
        check("zw_status",  {29'd0, id_ok, ts_ok, timeout_err}, 32'b110);
        check("zw_ts_val",  ts_value, EXP_TS);
        @(negedge clock);
        check("zw_done_pulse", {30'd0, done, busy}, 32'd0);
        check("zw_hold", {30'd0, id_ok, ts_ok}, 32'b11);

        // Timestamp off by one.
        ts_word = 32'h6722_B9AF;
        run_seq(32'h0, cyc, rd_pat, ad_pat);
        check("ts_bad_latency", cyc, 32'd4);
        check("ts_bad_status",  {29'd0, id_ok, ts_ok, timeout_err}, 32'b100);
        check("ts_bad_val",     ts_value, 32'h6722_B9AF);

        // Word 0 stuck: two 4-cycle attempts, one gap, then give up.
        run_seq(32'hFFFF_FFFF, cyc, rd_pat, ad_pat);
        waitreq = 1'b0;
        check("to_latency", cyc, 32'd10);
        check("to_read",    rd_pat, 32'h3DE);
        check("to_addr",    ad_pat, 32'h0);
        check("to_status",  {29'd0, id_ok, ts_ok, timeout_err}, 32'b001);

        // Three stalls on word 1 stay under the timeout; ID MSB mismatch.
        id_word = 32'h8000_0000;
        ts_word = EXP_TS;
        run_seq(32'h1C, cyc, rd_pat, ad_pat);
        check("st3_latency", cyc, 32'd7);
        check("st3_read",    rd_pat, 32'h3E);
        check("st3_addr",    ad_pat, 32'h3C);
        check("st3_status",  {29'd0, id_ok, ts_ok, timeout_err}, 32'b010);
        check("st3_id_val",  id_value, 32'h8000_0000);

        // One timeout on each word; retry budget is per word so both recover.
        id_word = 32'h0000_0000;
        run_seq(32'h79E, cyc, rd_pat, ad_pat);
        check("rty_latency", cyc, 32'd14);
        check("rty_read",    rd_pat, 32'h17DE);
        check("rty_addr",    ad_pat, 32'h1780);
        check("rty_status",  {29'd0, id_ok, ts_ok, timeout_err}, 32'b110);

        // start held high: back-to-back sequences with one IDLE cycle between.
        waitreq  = 1'b0;
        done_pat = '0;
        @(negedge clock);
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            done_pat[k] = done;
            if (k == 20) start = 1'b0;
        end
        check("held_done_pat", done_pat, 32'h0008_4210);

        // Extra start pulses while busy and in DONE are dropped.
        done_pat = '0;
        @(negedge clock);
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            start       = (k == 2) || (k == 4);
            done_pat[k] = done;
        end
        start = 1'b0;
        check("busy_start_pat", done_pat, 32'h10);

        // Reset during a word-1 stall.
        @(negedge clock);
        start   = 1'b1;
        waitreq = 1'b0;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        waitreq = 1'b1;
        @(negedge clock);
        check("pre_rst_read", {30'd0, avm_read, avm_address}, 32'b11);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_read", {31'd0, avm_read}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_status", {29'd0, id_ok, ts_ok, timeout_err}, 32'd0);
        check("mid_rst_vals", id_value | ts_value, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        waitreq = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            seen = seen | done | busy | avm_read;
        end
        check("post_rst_quiet", {31'd0, seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
